// File: rtl/asm_mem_arbiter.sv
// asm_mem_arbiter: two-requester scratchpad arbiter with an in2 starvation guard and read-return tagging
module asm_mem_arbiter #(
  parameter int MEM_DATAWIDTH = 128,
  parameter int MEM_ADDRWIDTH = 14,
  parameter int MEM_BSELWIDTH = MEM_DATAWIDTH/8,
  parameter int MAX_WAIT      = 4,
  parameter int RD_LATENCY    = 1
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     mem_in1_en_i,
  input  logic [MEM_BSELWIDTH-1:0] mem_in1_wben_i,
  input  logic [MEM_ADDRWIDTH-1:0] mem_in1_addr_i,
  input  logic [MEM_DATAWIDTH-1:0] mem_in1_wdata_i,
  output logic                     mem_in1_stall_o,
  output logic [MEM_DATAWIDTH-1:0] mem_in1_rdata_o,
  output logic                     mem_in1_rvalid_o,
  input  logic                     mem_in2_en_i,
  input  logic [MEM_BSELWIDTH-1:0] mem_in2_wben_i,
  input  logic [MEM_ADDRWIDTH-1:0] mem_in2_addr_i,
  input  logic [MEM_DATAWIDTH-1:0] mem_in2_wdata_i,
  output logic                     mem_in2_stall_o,
  output logic [MEM_DATAWIDTH-1:0] mem_in2_rdata_o,
  output logic                     mem_in2_rvalid_o,
  output logic                     mem_out_en_o,
  output logic [MEM_BSELWIDTH-1:0] mem_out_wben_o,
  output logic [MEM_ADDRWIDTH-1:0] mem_out_addr_o,
  output logic [MEM_DATAWIDTH-1:0] mem_out_wdata_o,
  input  logic [MEM_DATAWIDTH-1:0] mem_out_rdata_i,
  input  logic                     mem_out_stall_i,
  output logic                     starve_evt_o
);
  localparam int WW = MAX_WAIT > 0 ? $clog2(MAX_WAIT + 1) : 1;
  typedef enum logic {ARB, FORCE2} state_t;
  state_t                state;
  logic [WW-1:0]         wait_cnt;
  logic [RD_LATENCY-1:0] pipe_v, pipe_id;
  logic g1, g2, acc1, acc2, inc, force_go, rd_push;
  // ARB favours in1; FORCE2 favours in2 for exactly one accepted request
  assign g1 = state == ARB ? mem_in1_en_i : mem_in1_en_i & !mem_in2_en_i;
  assign g2 = state == ARB ? mem_in2_en_i & !mem_in1_en_i : mem_in2_en_i;
  assign mem_in1_stall_o = mem_out_stall_i | (mem_in1_en_i & !g1);
  assign mem_in2_stall_o = mem_out_stall_i | (mem_in2_en_i & !g2);
  assign acc1 = g1 & !mem_out_stall_i;
  assign acc2 = g2 & !mem_out_stall_i;
  assign mem_out_en_o    = g1 | g2;
  assign mem_out_wben_o  = g1 ? mem_in1_wben_i  : g2 ? mem_in2_wben_i  : '0;
  assign mem_out_addr_o  = g1 ? mem_in1_addr_i  : g2 ? mem_in2_addr_i  : '0;
  assign mem_out_wdata_o = g1 ? mem_in1_wdata_i : g2 ? mem_in2_wdata_i : '0;
  assign mem_in1_rdata_o = mem_out_rdata_i;
  assign mem_in2_rdata_o = mem_out_rdata_i;
  // a memory-side stall freezes the wait count so only arbitration losses count
  assign inc      = mem_in2_en_i & !acc2 & !mem_out_stall_i;
  assign force_go = MAX_WAIT != 0 && state == ARB && inc && wait_cnt == WW'(MAX_WAIT - 1);
  assign rd_push  = (acc1 | acc2) & ~|mem_out_wben_o;
  assign mem_in1_rvalid_o = pipe_v[RD_LATENCY-1] & !pipe_id[RD_LATENCY-1];
  assign mem_in2_rvalid_o = pipe_v[RD_LATENCY-1] & pipe_id[RD_LATENCY-1];
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      state        <= ARB;
      wait_cnt     <= '0;
      starve_evt_o <= 1'b0;
      pipe_v       <= '0;
      pipe_id      <= '0;
    end else begin
      wait_cnt     <= (!mem_in2_en_i || acc2) ? '0 :
                      (inc && wait_cnt != WW'(MAX_WAIT)) ? wait_cnt + 1'b1 : wait_cnt;
      starve_evt_o <= force_go;
      if (force_go) state <= FORCE2;
      else if (state == FORCE2 && (acc2 || !mem_in2_en_i)) state <= ARB;
      pipe_v  <= RD_LATENCY'({pipe_v, rd_push});
      pipe_id <= RD_LATENCY'({pipe_id, acc2});
    end
endmodule
